la_sample_capture: RTL

- Capture front-end of the logic analyzer; sits directly upstream of the VGA pixel renderer.
- Synchronises the probe channels and masks disabled channels.
- Fills a circular sample buffer with pre-trigger history, waits for an edge trigger on a selected channel, then records post-trigger samples.
- Afterwards serves the trace time-ordered through a read port that the renderer addresses with the timing generator's next column.

---
 rtl/la_sample_capture_pkg.sv | 21 ++
 rtl/la_sample_ram.sv | 28 ++
 rtl/la_sample_capture.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/la_sample_capture_pkg.sv
// rtl/la_sample_capture_pkg.sv - shared defaults, FSM encodings and helpers for the capture front-end
package la_sample_capture_pkg;

   localparam int LA_N_CHAN  = 10;
   localparam int LA_DEPTH   = 640;
   localparam int LA_ADDR_W  = 10;
   localparam int LA_PRETRIG = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } la_state_e;

   function automatic logic state_is_busy(input la_state_e s);
      return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/la_sample_ram.sv
// rtl/la_sample_ram.sv - simple dual-port sample buffer, synchronous write, registered read
module la_sample_ram #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // No reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/la_sample_capture.sv
// rtl/la_sample_capture.sv - logic analyzer capture: sync, mask, pre/post-trigger ring buffer, ordered readout
// Optional LA_DECIMATE_EN adds a decim port and a sample-strobe prescaler.
module la_sample_capture
   import la_sample_capture_pkg::*;
#(
   parameter int N_CHAN  = LA_N_CHAN,
   parameter int DEPTH   = LA_DEPTH,
   parameter int ADDR_W  = LA_ADDR_W,
   parameter int PRETRIG = LA_PRETRIG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CHAN-1:0] chan_in,
   input  logic [N_CHAN-1:0] chan_enable,
   input  logic [3:0]        trig_chan,
   input  logic              trig_rising,
   input  logic              force_trig,
   input  logic              arm,
`ifdef LA_DECIMATE_EN
   input  logic [7:0]        decim,
`endif
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [N_CHAN-1:0] rd_data,
   output logic              busy,
   output logic              capture_done
);

   localparam int POST_N = DEPTH - PRETRIG - 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   PRE_X     = (ADDR_W+1)'(PRETRIG);

   la_state_e         state_q, state_d;
   logic [N_CHAN-1:0] sync1_q, sync2_q;
   logic [N_CHAN-1:0] prev_samp_q, prev_samp_d;
   logic              prev_valid_q, prev_valid_d;
   logic              force_pend_q, force_pend_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_valid_q, rd_valid_d;

   logic [N_CHAN-1:0] masked;
   logic              strobe;
   logic              we;
   logic              sel_cur, sel_prev, edge_hit, trig_hit;
   logic [ADDR_W:0]   start_ext, phys_ext;
   logic              rd_in_range;
   logic [ADDR_W-1:0] raddr;
   logic [N_CHAN-1:0] ram_rdata;

`ifdef LA_DECIMATE_EN
   logic [7:0] presc_q, presc_d;

   always_comb begin
      strobe  = (presc_q >= decim);
      presc_d = strobe ? 8'd0 : presc_q + 8'd1;
      if (arm && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         presc_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= 8'd0;
      else       presc_q <= presc_d;
   end
`else
   assign strobe = 1'b1;
`endif

   always_comb begin
      masked   = sync2_q & chan_enable;
      sel_cur  = 1'b0;
      sel_prev = 1'b0;
      // Out-of-range channel indices match nothing, so they can never trigger.
      for (int i = 0; i < N_CHAN; i++) begin
         if (trig_chan == 4'(i)) begin
            sel_cur  = masked[i];
            sel_prev = prev_samp_q[i];
         end
      end
      edge_hit = prev_valid_q && (trig_rising ? (!sel_prev && sel_cur) : (sel_prev && !sel_cur));
      trig_hit = edge_hit || force_trig || force_pend_q;
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      cnt_d        = cnt_q;
      trig_ptr_d   = trig_ptr_q;
      prev_samp_d  = prev_samp_q;
      prev_valid_d = prev_valid_q;
      force_pend_d = force_pend_q;
      we           = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               wr_ptr_d     = '0;
               cnt_d        = '0;
               prev_valid_d = 1'b0;
               force_pend_d = 1'b0;
               if (PRETRIG == 0) state_d = ST_WAIT_TRIG;
               else              state_d = ST_PRE;
            end
         end
         ST_PRE: begin
            if (strobe) begin
               we    = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == PRE_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_WAIT_TRIG;
               end
            end
         end
         ST_WAIT_TRIG: begin
            // A forced trigger between strobes is held for the next strobed sample.
            if (force_trig && !strobe) force_pend_d = 1'b1;
            if (strobe) begin
               we = 1'b1;
               if (trig_hit) begin
                  trig_ptr_d   = wr_ptr_q;
                  cnt_d        = '0;
                  force_pend_d = 1'b0;
                  if (POST_N == 0) state_d = ST_DONE;
                  else             state_d = ST_POST;
               end
            end
         end
         ST_POST: begin
            if (strobe) begin
               we    = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == POST_LAST) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (we) begin
         wr_ptr_d     = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
         prev_samp_d  = masked;
         prev_valid_d = 1'b1;
      end
      busy_d = state_is_busy(state_d);
      done_d = (state_d == ST_DONE);
   end

   always_comb begin
      start_ext = {1'b0, trig_ptr_q} + DEPTH_X - PRE_X;
      if (start_ext >= DEPTH_X) start_ext = start_ext - DEPTH_X;
      phys_ext = start_ext + {1'b0, rd_addr};
      if (phys_ext >= DEPTH_X) phys_ext = phys_ext - DEPTH_X;
      rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
      raddr       = rd_in_range ? phys_ext[ADDR_W-1:0] : '0;
      rd_valid_d  = rd_in_range && (state_q == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sync1_q      <= '0;
         sync2_q      <= '0;
         prev_samp_q  <= '0;
         prev_valid_q <= 1'b0;
         force_pend_q <= 1'b0;
         wr_ptr_q     <= '0;
         cnt_q        <= '0;
         trig_ptr_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= chan_in;
         sync2_q      <= sync1_q;
         prev_samp_q  <= prev_samp_d;
         prev_valid_q <= prev_valid_d;
         force_pend_q <= force_pend_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
         trig_ptr_q   <= trig_ptr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   la_sample_ram #(
      .DATA_W (N_CHAN),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (masked),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   // Gating by the reset-cleared valid flag zeroes rd_data as soon as reset asserts.
   assign rd_data      = ram_rdata & {N_CHAN{rd_valid_q}};
   assign busy         = busy_q;
   assign capture_done = done_q;

endmodule
